// File: rtl/bitty_pkg.sv
// Shared types and encodings for the parametrised Bitty core.
// Covers FSM states, ALU op codes, instruction formats and CMP result codes.
package bitty_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_S = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  localparam logic [1:0] FMT_RR  = 2'b00;
  localparam logic [1:0] FMT_IMM = 2'b01;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Both 10 and 11 are reserved, so the upper format bit alone marks them.
  function automatic logic fmt_reserved(input logic [1:0] fmt);
    return fmt[1];
  endfunction

endpackage

// File: rtl/bitty_alu_param.sv
// Combinational Bitty ALU: eight operations on DATA_W-bit operands.
// CMP returns its unsigned ordering code both as the result and on the cmp output.
module bitty_alu_param import bitty_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic [1:0]        cmp
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    if (a == b)     cmp = CMP_EQ;
    else if (a > b) cmp = CMP_GT;
    else            cmp = CMP_LT;
  end

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_CMP:  y = {{(DATA_W-2){1'b0}}, cmp};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitty_core_param.sv
// Parametrised multi-cycle Bitty core: register file, operand mux and sequencing FSM.
// One instruction per handshake, LOAD_S -> EXEC -> WB, with a combinational debug read port.
//
// state  | meaning
// IDLE   | inst_ready high, waiting for inst_valid
// LOAD_S | latch R[rx] into regS
// EXEC   | regC <= alu(regS, operand)
// WB     | done (and illegal) pulse, commit regC / cmp_flag at exit
module bitty_core_param import bitty_pkg::*; #(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  parameter  int INST_W = 16,
  localparam int RS     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic              done,
  output logic              illegal,
  output logic [1:0]        cmp_flag,
  input  logic [RS-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IMM_W = INST_W - RS - 5;

  state_e            state;
  logic [INST_W-1:0] inst_q;
  logic [DATA_W-1:0] reg_s;
  logic [DATA_W-1:0] reg_c;
  logic [DATA_W-1:0] regs [NREGS];

  logic [RS-1:0]     rx;
  logic [RS-1:0]     ry;
  logic [2:0]        op;
  logic [1:0]        fmt;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] alu_y;
  logic [1:0]        alu_cmp;

  assign rx  = inst_q[INST_W-1 -: RS];
  assign ry  = inst_q[INST_W-1-RS -: RS];
  assign op  = inst_q[4:2];
  assign fmt = inst_q[1:0];
  assign imm = inst_q[INST_W-1-RS:5];

  generate
    if (IMM_W >= DATA_W) begin : g_imm_trunc
      assign imm_ext = imm[DATA_W-1:0];
    end else begin : g_imm_zext
      assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
    end
  endgenerate

  // Register operand is read in EXEC, so rx==ry sees the pre-write value.
  always_comb begin
    operand = regs[ry];
    if (fmt == FMT_IMM) operand = imm_ext;
  end

  bitty_alu_param #(.DATA_W(DATA_W)) u_alu (
    .a   (reg_s),
    .b   (operand),
    .op  (op),
    .y   (alu_y),
    .cmp (alu_cmp)
  );

  assign inst_ready = (state == IDLE);
  assign dbg_data   = regs[dbg_sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      inst_q  <= '0;
      reg_s   <= '0;
      reg_c   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid) begin
            inst_q <= inst;
            state  <= LOAD_S;
          end
        end
        LOAD_S: begin
          reg_s <= regs[rx];
          state <= EXEC;
        end
        EXEC: begin
          reg_c   <= alu_y;
          done    <= 1'b1;
          illegal <= fmt_reserved(fmt);
          state   <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit happens on the edge leaving WB; the CMP code already sits in regC[1:0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      cmp_flag <= CMP_EQ;
    end else if (state == WB && !fmt_reserved(fmt)) begin
      regs[rx] <= reg_c;
      if (op == OP_CMP) cmp_flag <= reg_c[1:0];
    end
  end

  logic unused_alu_cmp;
  assign unused_alu_cmp = ^alu_cmp;

endmodule

// File: tb/tb_bitty_core_param.sv
// Directed bench for bitty_core_param: 16-bit/8-reg build plus a 32-bit/16-reg build.
// Expected register contents are hand-computed alongside each instruction.
module tb_bitty_core_param;
  import bitty_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] inst16;
  logic        valid16, ready16, done16, ill16;
  logic [1:0]  cmp16;
  logic [2:0]  sel16;
  logic [15:0] dbg16;

  logic [15:0] inst32;
  logic        valid32, ready32, done32, ill32;
  logic [1:0]  cmp32;
  logic [3:0]  sel32;
  logic [31:0] dbg32;

  bitty_core_param #(.DATA_W(16), .NREGS(8), .INST_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .inst(inst16), .inst_valid(valid16), .inst_ready(ready16),
    .done(done16), .illegal(ill16), .cmp_flag(cmp16), .dbg_sel(sel16), .dbg_data(dbg16)
  );

  bitty_core_param #(.DATA_W(32), .NREGS(16), .INST_W(16)) u_dut32 (
    .clk(clk), .reset(reset), .inst(inst32), .inst_valid(valid32), .inst_ready(ready32),
    .done(done32), .illegal(ill32), .cmp_flag(cmp32), .dbg_sel(sel32), .dbg_data(dbg32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr16(input int rx, input int ry, input logic [2:0] op,
                                       input logic [1:0] fmt);
    logic [2:0] x, y;
    x = rx[2:0];
    y = ry[2:0];
    return {x, y, 5'b00000, op, fmt};
  endfunction

  function automatic logic [15:0] imm16(input int rx, input int imm, input logic [2:0] op);
    logic [2:0] x;
    logic [7:0] v;
    x = rx[2:0];
    v = imm[7:0];
    return {x, v, op, FMT_IMM};
  endfunction

  function automatic logic [15:0] imm32(input int rx, input int imm, input logic [2:0] op);
    logic [3:0] x;
    logic [6:0] v;
    x = rx[3:0];
    v = imm[6:0];
    return {x, v, op, FMT_IMM};
  endfunction

  // Offer one instruction, then scramble inst to show post-accept changes are ignored.
  task automatic run16(input logic [15:0] i, input string tag, input logic exp_ill);
    int k;
    @(negedge clk);
    inst16  = i;
    valid16 = 1'b1;
    k = 0;
    while (!ready16 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, ready16, 1);
    @(posedge clk);
    #1;
    inst16  = 16'hFFFF;
    valid16 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done16 && k < 8);
    chk({tag, "_lat"}, k, 3);
    chk({tag, "_ill"}, ill16, exp_ill);
    @(negedge clk);
    chk({tag, "_pulse"}, done16, 0);
  endtask

  task automatic reg16(input int idx, input logic [15:0] exp, input string tag);
    sel16 = idx[2:0];
    #1;
    chk(tag, dbg16, exp);
  endtask

  task automatic run32(input logic [15:0] i, input string tag);
    int k;
    @(negedge clk);
    chk({tag, "_ready"}, ready32, 1);
    inst32  = i;
    valid32 = 1'b1;
    @(posedge clk);
    #1;
    inst32  = 16'hFFFF;
    valid32 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done32 && k < 8);
    chk({tag, "_lat"}, k, 3);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dn, lo, a0, a1, d0, d1, cnt;
    logic take;

    reset = 1'b0;
    inst16 = '0; valid16 = 1'b0; sel16 = '0;
    inst32 = '0; valid32 = 1'b0; sel32 = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", done16, 0);
    chk("rst_ill", ill16, 0);
    chk("rst_cmp", cmp16, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready16, 1);
    for (int i = 0; i < 8; i++) reg16(i, 16'h0000, "rst_reg");

    // ADD immediate
    run16(imm16(1, 5, OP_ADD), "add_imm", 1'b0);
    reg16(1, 16'h0005, "add_imm_r1");

    // SUB wrap and CMP greater-than
    run16(imm16(2, 7, OP_ADD), "add_r2", 1'b0);
    reg16(2, 16'h0007, "add_r2_val");
    run16(rr16(1, 2, OP_SUB, FMT_RR), "sub", 1'b0);
    reg16(1, 16'hFFFE, "sub_wrap");
    run16(rr16(1, 2, OP_CMP, FMT_RR), "cmp_gt", 1'b0);
    reg16(1, 16'h0001, "cmp_gt_r1");
    chk("cmp_gt_flag", cmp16, 2'b01);

    // Reserved formats: no register or flag change
    run16(rr16(1, 2, OP_ADD, 2'b10), "rsv10", 1'b1);
    reg16(1, 16'h0001, "rsv10_r1");
    reg16(2, 16'h0007, "rsv10_r2");
    run16(rr16(0, 2, OP_CMP, 2'b11), "rsv11", 1'b1);
    reg16(0, 16'h0000, "rsv11_r0");
    chk("rsv_flag", cmp16, 2'b01);

    // Back-to-back handshake with inst_valid held high
    @(negedge clk);
    inst16 = imm16(4, 3, OP_ADD);
    valid16 = 1'b1;
    acc = 0; dn = 0; lo = 0; a0 = -1; a1 = -1; d0 = -1; d1 = -1;
    for (int c = 0; c < 12; c++) begin
      if (done16) begin
        if (dn == 0) d0 = c; else d1 = c;
        dn++;
      end
      if (!ready16) lo++;
      take = ready16 && valid16;
      if (take) begin
        if (acc == 0) a0 = c; else a1 = c;
        acc++;
      end
      @(posedge clk);
      #1;
      if (take) begin
        if (acc == 1) inst16 = imm16(4, 4, OP_ADD);
        else valid16 = 1'b0;
      end
      @(negedge clk);
    end
    chk("hs_accepts", acc, 2);
    chk("hs_dones", dn, 2);
    chk("hs_spacing", a1 - a0, 4);
    chk("hs_lat0", d0 - a0, 3);
    chk("hs_lat1", d1 - a1, 3);
    chk("hs_ready_low", lo, 6);
    reg16(4, 16'h0007, "hs_r4");

    // Shifts, rx==ry, logic ops, CMP eq/lt
    run16(imm16(3, 1, OP_ADD), "r3_one", 1'b0);
    run16(imm16(3, 15, OP_SHL), "r3_shl15", 1'b0);
    run16(imm16(3, 1, OP_ADD), "r3_or1", 1'b0);
    reg16(3, 16'h8001, "r3_8001");
    run16(imm16(3, 1, OP_SHL), "shl1", 1'b0);
    reg16(3, 16'h0002, "shl1_r3");
    run16(imm16(3, 17, OP_SHR), "shr17", 1'b0);
    reg16(3, 16'h0001, "shr17_r3");
    run16(rr16(3, 3, OP_ADD, FMT_RR), "self_add", 1'b0);
    reg16(3, 16'h0002, "self_add_r3");
    run16(imm16(2, 5, OP_AND), "and_imm", 1'b0);
    reg16(2, 16'h0005, "and_r2");
    run16(imm16(2, 8'h30, OP_OR), "or_imm", 1'b0);
    reg16(2, 16'h0035, "or_r2");
    run16(rr16(2, 4, OP_XOR, FMT_RR), "xor_rr", 1'b0);
    reg16(2, 16'h0032, "xor_r2");
    run16(rr16(4, 4, OP_CMP, FMT_RR), "cmp_eq", 1'b0);
    reg16(4, 16'h0000, "cmp_eq_r4");
    chk("cmp_eq_flag", cmp16, 2'b00);
    run16(imm16(0, 3, OP_CMP), "cmp_lt", 1'b0);
    reg16(0, 16'h0002, "cmp_lt_r0");
    chk("cmp_lt_flag", cmp16, 2'b10);

    // Reset asserted during EXEC aborts the instruction
    @(negedge clk);
    inst16 = imm16(5, 9, OP_ADD);
    valid16 = 1'b1;
    @(posedge clk);
    #1;
    valid16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_done", done16, 0);
    chk("abort_ready", ready16, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done16) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_ready_after", ready16, 1);
    chk("abort_cmp", cmp16, 0);
    for (int i = 0; i < 8; i++) reg16(i, 16'h0000, "abort_reg");

    // 32-bit / 16-register build
    run32(imm32(15, 5, OP_ADD), "w32_add");
    sel32 = 4'd15;
    #1;
    chk("w32_r15", dbg32, 32'h0000_0005);
    run32(imm32(15, 7, OP_SUB), "w32_sub");
    sel32 = 4'd15;
    #1;
    chk("w32_wrap", dbg32, 32'hFFFF_FFFE);
    chk("w32_ill", ill32, 0);
    chk("w32_cmp", cmp32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
